// File: rtl/sram_puf_reader.sv
// Streams a window of RAM words (power-up PUF contents) out on a valid/ready port, one word
// per READ/WAIT/OUT pass. Define SRAM_PUF_SCRUB_EN to overwrite each word once it is accepted.
module sram_puf_reader #(
  parameter int unsigned         ADDR_W      = 13,
  parameter int unsigned         DATA_W      = 16,
  parameter logic [DATA_W-1:0]   SCRUB_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StOut, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] m_data_q;
  logic [ADDR_W-1:0] m_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      last_q   <= '0;
      m_data_q <= '0;
      m_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q  <= start_addr;
            last_q  <= end_addr;
            // An inverted window is an empty scan: report completion without touching the RAM.
            state_q <= (start_addr > end_addr) ? StDone : StRead;
          end
        end
        StRead: state_q <= StWait;
        StWait: begin
          m_data_q <= ram_rdata;
          m_addr_q <= addr_q;
          state_q  <= StOut;
        end
        StOut: begin
          if (m_ready) begin
            // Compare before incrementing so the top address never wraps back to zero.
            if (addr_q == last_q) begin
              state_q <= StDone;
            end else begin
              addr_q  <= addr_q + AddrOne;
              state_q <= StRead;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign m_valid   = (state_q == StOut);
  assign m_data    = m_data_q;
  assign m_addr    = m_addr_q;
  assign ram_raddr = addr_q;
  assign ram_wdata = SCRUB_VALUE;
  assign ram_wmask = '0;

`ifdef SRAM_PUF_SCRUB_EN
  // Scrub the word in the same cycle it is handed downstream.
  assign ram_we    = (state_q == StOut) && m_ready;
  assign ram_waddr = m_addr_q;
`else
  assign ram_we    = 1'b0;
  assign ram_waddr = addr_q;
`endif

endmodule

// File: tb/tb_sram_puf_reader.sv
// Directed bench for sram_puf_reader: behavioural RAM preloaded with 0xA000+addr,
// a transfer monitor, and hand-computed expectations per scan.
module tb_sram_puf_reader;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic              busy, done;
  logic [ADDR_W-1:0] ram_raddr, ram_waddr;
  logic [DATA_W-1:0] ram_rdata, ram_wdata, ram_wmask;
  logic              ram_we;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_valid, m_ready;

  sram_puf_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SCRUB_VALUE(16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .busy      (busy),
    .done      (done),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .m_data    (m_data),
    .m_addr    (m_addr),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= (mem[ram_waddr] & ram_wmask) | (ram_wdata & ~ram_wmask);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int n_done   = 0;
  int n_we     = 0;
  bit saw_zero = 1'b0;
  logic [ADDR_W-1:0] xa[$];
  logic [DATA_W-1:0] xd[$];
  int                xc[$];

  // Transfers happen on the rising edge; the monitor records the values being accepted there.
  always @(posedge clk) begin
    cycle++;
    if (m_valid && m_ready) begin
      xa.push_back(m_addr);
      xd.push_back(m_data);
      xc.push_back(cycle);
    end
    if (done) n_done++;
    if (ram_we) n_we++;
    if (busy && ram_raddr == '0) saw_zero = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'hA000 + 16'(i);
  endtask

  task automatic clear_mon();
    preload();
    xa.delete();
    xd.delete();
    xc.delete();
    n_done   = 0;
    saw_zero = 1'b0;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", 32'(seen), 1);
    if (seen) @(negedge clk);
  endtask

  task automatic check_xfers(input string tag, input int n, input logic [ADDR_W-1:0] a0);
    check({tag, "_count"}, xa.size(), n);
    for (int i = 0; i < n && i < xa.size(); i++) begin
      check({tag, "_addr"}, 32'(xa[i]), 32'(a0 + ADDR_W'(i)));
      check({tag, "_data"}, 32'(xd[i]), 32'(16'hA000 + 16'(a0) + 16'(i)));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_we"},    32'(ram_we), 0);
    check({tag, "_mdata"}, 32'(m_data), 0);
    check({tag, "_maddr"}, 32'(m_addr), 0);
    check({tag, "_raddr"}, 32'(ram_raddr), 0);
    check({tag, "_wmask"}, 32'(ram_wmask), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_we0;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    m_ready    = 1'b1;
    preload();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic scan 0..3 with latency and throughput
    clear_mon();
    launch(13'h0000, 13'h0003);
    check("t1_busy_read", 32'(busy), 1);
    check("t1_valid_c1", 32'(m_valid), 0);
    @(negedge clk);
    check("t1_valid_c2", 32'(m_valid), 0);
    @(negedge clk);
    check("t1_valid_c3", 32'(m_valid), 1);
    check("t1_first_data", 32'(m_data), 32'h0000A000);
    wait_done(40);
    check_xfers("t1", 4, 13'h0000);
    for (int i = 1; i < xc.size(); i++) check("t1_spacing", xc[i] - xc[i-1], 3);
    check("t1_done_count", n_done, 1);
    check("t1_idle", 32'(busy), 0);

    // Top-of-memory window must not wrap
    clear_mon();
    launch(13'h1FFE, 13'h1FFF);
    wait_done(40);
    check_xfers("t2", 2, 13'h1FFE);
    check("t2_no_zero_read", 32'(saw_zero), 0);
    check("t2_done_count", n_done, 1);

    // Inverted window: done only, no words
    clear_mon();
    launch(13'h0010, 13'h000F);
    check("t3_done", 32'(done), 1);
    check("t3_valid", 32'(m_valid), 0);
    @(negedge clk);
    check("t3_done_drop", 32'(done), 0);
    check("t3_idle", 32'(busy), 0);
    check("t3_count", xa.size(), 0);
    check("t3_done_count", n_done, 1);

    // Backpressure and ignored start while busy
    clear_mon();
    m_ready = 1'b0;
    launch(13'h0020, 13'h0021);
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
    check("t4_valid", 32'(m_valid), 1);
    start_addr = 13'h0100;
    end_addr   = 13'h0100;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      @(negedge clk);
      check("t4_hold_valid", 32'(m_valid), 1);
      check("t4_hold_data", 32'(m_data), 32'h0000A020);
      check("t4_hold_addr", 32'(m_addr), 32'h20);
    end
    start   = 1'b0;
    m_ready = 1'b1;
    wait_done(40);
    check_xfers("t4", 2, 13'h0020);
    check("t4_done_count", n_done, 1);
    @(negedge clk);
    check("t4_no_rescan", 32'(busy), 0);

    // Reset during WAIT of the second word
    clear_mon();
    launch(13'h0030, 13'h0033);
    for (int i = 0; i < 20 && xa.size() < 1; i++) @(negedge clk);
    check("t5_first_xfer", xa.size(), 1);
    @(negedge clk);
    check("t5_in_wait_raddr", 32'(ram_raddr), 32'h31);
    check("t5_in_wait_valid", 32'(m_valid), 0);
    rst = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle_after", 32'(busy), 0);
    check("t5_no_done", n_done, 0);
    clear_mon();
    launch(13'h0040, 13'h0040);
    wait_done(40);
    check_xfers("t5_new", 1, 13'h0040);

`ifdef SRAM_PUF_SCRUB_EN
    clear_mon();
    n_we0 = n_we;
    launch(13'h0000, 13'h0001);
    wait_done(40);
    check_xfers("scrub1", 2, 13'h0000);
    check("scrub1_writes", n_we - n_we0, 2);
    xa.delete();
    xd.delete();
    launch(13'h0000, 13'h0001);
    wait_done(40);
    check("scrub2_count", xd.size(), 2);
    for (int i = 0; i < xd.size(); i++) check("scrub2_data", 32'(xd[i]), 0);
`else
    n_we0 = 0;
    check("no_writes", n_we, n_we0);
`endif
    check("final_wmask", 32'(ram_wmask), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
